// File: rtl/mmio_monitor_pkg.sv
// -----------------------------------------------------------------------------
// mmio_monitor_pkg
//
// Shared definitions for the MMIO monitor: monitor state encoding, fault cause
// codes and the default console / exit register addresses. The testbench
// imports the same addresses so both sides agree on the memory map.
// -----------------------------------------------------------------------------
package mmio_monitor_pkg;

  // Monitor life cycle: RUN until EXIT or a fault, DRAIN while buffered
  // console bytes are still leaving, then one of two terminal states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_e;

  // Encoding of the fault_cause output.
  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_IMEM    = 2'd1,
    CAUSE_DMEM    = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;

  localparam logic [31:0] DEFAULT_PUTC_ADDR = 32'h8000_001c;
  localparam logic [31:0] DEFAULT_EXIT_ADDR = 32'h8000_002c;

endpackage : mmio_monitor_pkg

// File: rtl/mmio_monitor_fifo.sv
// -----------------------------------------------------------------------------
// mmio_monitor_fifo
//
// Synchronous show-ahead FIFO. head_data presents the oldest entry whenever
// the FIFO is not empty, so a consumer can treat !empty as "valid" and pop in
// the same cycle it looks at the data. A push while full is accepted only if a
// pop happens in the same cycle; otherwise it is ignored (the caller decides
// what a dropped write means).
//
// Parameters:
//   WIDTH  entry width in bits
//   DEPTH  number of entries; power of two, >= 2
//
// Ports:
//   clk        clock
//   resetb     synchronous reset, active-high
//   push       write request
//   push_data  data to write
//   pop        read request (ignored when empty)
//   head_data  oldest entry, forced to 0 when empty
//   full       DEPTH entries stored
//   empty      no entries stored
//   level      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module mmio_monitor_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == LW'(DEPTH));
  assign level   = count_q;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // the design samples pre-edge values, independent of block ordering.
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + LW'(1);
        2'b01:   count_q <= count_q - LW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through head_data, which is masked while empty, so stale entries are
  // harmless and the array can map onto plain RAM/flops without reset logic.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule : mmio_monitor_fifo

// File: rtl/mmio_monitor.sv
// -----------------------------------------------------------------------------
// mmio_monitor
//
// Snoops the core's data-memory write port and fetch PC. Console (PUTC)
// bytes are buffered in a show-ahead FIFO drained through a valid/ready port;
// a write to the EXIT register captures the exit code and, once the console
// FIFO has emptied, halts. Out-of-range fetches, out-of-range data writes and
// a PC that stops moving for too long put the monitor into a sticky FAULT.
//
// Build option: define MMIO_MONITOR_CNT_EN to implement the cycle and
// retired-instruction counters; without it both counter outputs read 0.
//
// Ports:
//   clk          clock
//   resetb       synchronous reset, active-high
//   wr_en        data-memory write strobe
//   wr_addr      byte write address
//   wr_data      write data
//   wr_strb      byte strobes (only lane 0 matters, for PUTC)
//   pc           fetch PC
//   retire       one instruction retired this cycle
//   tx_valid     console FIFO head valid
//   tx_data      console FIFO head byte
//   tx_ready     sink accepts head
//   fifo_level   console FIFO occupancy
//   overflow     sticky, a console byte was dropped
//   halt         sticky, program ended or faulted
//   exit_code    captured EXIT data
//   fault        sticky fault flag
//   fault_cause  0 none, 1 IMEM range, 2 DMEM range, 3 timeout
//   fault_addr   offending pc or wr_addr
//   cycle_cnt    cycles spent in RUN/DRAIN since reset
//   instret_cnt  retired instructions in RUN/DRAIN since reset
// -----------------------------------------------------------------------------
module mmio_monitor
  import mmio_monitor_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] PUTC_ADDR      = ADDR_W'(DEFAULT_PUTC_ADDR),
  parameter logic [ADDR_W-1:0] EXIT_ADDR      = ADDR_W'(DEFAULT_EXIT_ADDR),
  parameter int unsigned       IMEM_LOG2      = 17,
  parameter int unsigned       DMEM_LOG2      = 18,
  parameter int unsigned       FIFO_DEPTH     = 16,
  parameter int unsigned       TIMEOUT_CYCLES = 100,
  parameter int unsigned       CNT_W          = 32
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [31:0]                   wr_data,
  input  logic [3:0]                    wr_strb,
  input  logic [ADDR_W-1:0]             pc,
  input  logic                          retire,
  output logic                          tx_valid,
  output logic [7:0]                    tx_data,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          halt,
  output logic [31:0]                   exit_code,
  output logic                          fault,
  output logic [1:0]                    fault_cause,
  output logic [ADDR_W-1:0]             fault_addr,
  output logic [CNT_W-1:0]              cycle_cnt,
  output logic [CNT_W-1:0]              instret_cnt
);

  localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STALL_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic               overflow_q;
  logic [31:0]        exit_code_q;
  cause_e             cause_q, cause_d;
  logic [ADDR_W-1:0]  fault_addr_q, fault_addr_d;
  logic [ADDR_W-1:0]  prev_pc_q;
  logic [STALL_W-1:0] stall_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic addr_is_putc, addr_is_exit;
  logic is_putc, is_exit;
  logic running, checking;
  logic imem_bad, dmem_bad, pc_match, timeout_hit;
  logic fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic empty_after_pop;
  logic overflow_set, exit_we, capture;

  assign addr_is_putc = (wr_addr == PUTC_ADDR);
  assign addr_is_exit = (wr_addr == EXIT_ADDR);
  assign is_putc      = wr_en && addr_is_putc && wr_strb[0];
  assign is_exit      = wr_en && addr_is_exit;

  assign running      = (state_q == RUN);
  assign checking     = (state_q == RUN) || (state_q == DRAIN);

  // Range checks: any set bit above the legal window is a violation. MMIO
  // registers live outside DMEM, so they are excluded from the write check.
  assign imem_bad     = ((pc >> IMEM_LOG2) != '0);
  assign dmem_bad     = wr_en && !addr_is_putc && !addr_is_exit &&
                        ((wr_addr >> DMEM_LOG2) != '0);

  assign pc_match     = (pc == prev_pc_q);
  assign timeout_hit  = pc_match && (stall_q == STALL_MAX);

  // ---------------------------------------------------------------------------
  // Console FIFO
  // ---------------------------------------------------------------------------
  assign tx_valid     = !fifo_empty;
  assign fifo_pop     = tx_valid && tx_ready;
  assign fifo_push    = running && is_putc;
  assign overflow_set = fifo_push && fifo_full && !fifo_pop;

  // The FIFO is empty after this edge if it is empty now (EXIT and PUTC share
  // one write port, so nothing can be pushed alongside an EXIT) or the last
  // entry is being popped this cycle.
  assign empty_after_pop = fifo_empty || ((fifo_level == LVL_W'(1)) && fifo_pop);

  mmio_monitor_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetb    (resetb),
    .push      (fifo_push),
    .push_data (wr_data[7:0]),
    .pop       (fifo_pop),
    .head_data (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // Within one cycle: IMEM > DMEM > EXIT > timeout. An EXIT that loses to a
  // range fault is not taken, so exit_code keeps its previous value.
  always_comb begin
    // NOTE: every signal written here is given a default first, so no path
    // through the case/if tree leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    cause_d      = CAUSE_NONE;
    fault_addr_d = '0;
    capture      = 1'b0;
    exit_we      = 1'b0;

    case (state_q)
      RUN, DRAIN: begin
        if (imem_bad) begin
          state_d      = FAULT;
          cause_d      = CAUSE_IMEM;
          fault_addr_d = pc;
          capture      = 1'b1;
        end else if (dmem_bad) begin
          state_d      = FAULT;
          cause_d      = CAUSE_DMEM;
          fault_addr_d = wr_addr;
          capture      = 1'b1;
        end else if (running && is_exit) begin
          exit_we = 1'b1;
          state_d = empty_after_pop ? DONE : DRAIN;
        end else if (timeout_hit) begin
          state_d      = FAULT;
          cause_d      = CAUSE_TIMEOUT;
          fault_addr_d = pc;
          capture      = 1'b1;
        end else if ((state_q == DRAIN) && empty_after_pop) begin
          state_d = DONE;
        end
      end
      default: state_d = state_q;  // DONE and FAULT hold until reset
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q      <= RUN;
      overflow_q   <= 1'b0;
      exit_code_q  <= '0;
      cause_q      <= CAUSE_NONE;
      fault_addr_q <= '0;
      prev_pc_q    <= '0;
      stall_q      <= '0;
    end else begin
      state_q <= state_d;
      if (overflow_set) overflow_q  <= 1'b1;
      if (exit_we)      exit_code_q <= wr_data;
      if (capture) begin
        cause_q      <= cause_d;
        fault_addr_q <= fault_addr_d;
      end
      // Stall tracking runs in every state; it only matters in RUN/DRAIN.
      prev_pc_q <= pc;
      if (!pc_match)               stall_q <= '0;
      else if (stall_q != STALL_MAX) stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign overflow    = overflow_q;
  assign exit_code   = exit_code_q;
  assign halt        = (state_q == DONE) || (state_q == FAULT);
  assign fault       = (state_q == FAULT);
  assign fault_cause = cause_q;
  assign fault_addr  = fault_addr_q;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef MMIO_MONITOR_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (resetb) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else if (checking) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  logic unused_retire;
  logic unused_checking;

  assign unused_retire   = retire;
  assign unused_checking = checking;
  assign cycle_cnt       = '0;
  assign instret_cnt     = '0;
`endif

  // Only byte lane 0 is significant (PUTC); the other strobes are ignored.
  logic unused_strb;
  assign unused_strb = ^wr_strb[3:1];

endmodule : mmio_monitor

// File: tb/tb_mmio_monitor.sv
// -----------------------------------------------------------------------------
// tb_mmio_monitor
//
// Directed vector table and hand-written sequences for the corner cases,
// followed by randomized traffic. A behavioural model (byte queue plus a few
// flags) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_mmio_monitor;
  import mmio_monitor_pkg::*;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 4;
`ifdef MMIO_MONITOR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        resetb;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic [31:0] pc;
  logic        retire;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [4:0]  fifo_level;
  logic        overflow;
  logic        halt;
  logic [31:0] exit_code;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  mmio_monitor #(
    .ADDR_W         (32),
    .PUTC_ADDR      (DEFAULT_PUTC_ADDR),
    .EXIT_ADDR      (DEFAULT_EXIT_ADDR),
    .IMEM_LOG2      (17),
    .DMEM_LOG2      (18),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT),
    .CNT_W          (32)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_strb     (wr_strb),
    .pc          (pc),
    .retire      (retire),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .halt        (halt),
    .exit_code   (exit_code),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_addr  (fault_addr),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the console is a byte queue; the program is either
  // running, waiting for its console to empty, or finished (cleanly or not).
  // ---------------------------------------------------------------------------
  logic [7:0]  mq[$];
  bit          m_ovf, m_halted, m_faulted, m_draining;
  logic [1:0]  m_cause;
  logic [31:0] m_faddr, m_exit, m_cyc, m_ins, m_prev_pc;
  int          m_same;  // consecutive edges at which pc equalled its previous value

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_halted = 0; m_faulted = 0; m_draining = 0;
    m_cause = 2'd0; m_faddr = 0; m_exit = 0; m_cyc = 0; m_ins = 0;
    m_prev_pc = 0; m_same = 0;
  endtask

  task automatic model_fault(input logic [1:0] cause, input logic [31:0] addr);
    m_halted  = 1;
    m_faulted = 1;
    m_cause   = cause;
    m_faddr   = addr;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit active, running, putc, ex, imem, dmem, tmo;
    if (resetb) begin
      model_reset();
      return;
    end
    active  = !m_halted;
    running = active && !m_draining;
    putc    = wr_en && (wr_addr == DEFAULT_PUTC_ADDR) && wr_strb[0];
    ex      = wr_en && (wr_addr == DEFAULT_EXIT_ADDR);
    imem    = (pc >= 32'h0002_0000);
    dmem    = wr_en && (wr_addr != DEFAULT_PUTC_ADDR) && (wr_addr != DEFAULT_EXIT_ADDR) &&
              (wr_addr >= 32'h0004_0000);
    tmo     = (pc == m_prev_pc) && (m_same >= TIMEOUT);

    if (mq.size() > 0 && tx_ready) void'(mq.pop_front());
    if (running && putc) begin
      if (mq.size() < DEPTH) mq.push_back(wr_data[7:0]);
      else m_ovf = 1;
    end
    if (active) begin
      if (imem)      model_fault(2'd1, pc);
      else if (dmem) model_fault(2'd2, wr_addr);
      else if (running && ex) begin
        m_exit = wr_data;
        if (mq.size() == 0) m_halted = 1;
        else m_draining = 1;
      end
      else if (tmo) model_fault(2'd3, pc);
      else if (m_draining && mq.size() == 0) m_halted = 1;
      m_cyc++;
      if (retire) m_ins++;
    end
    m_same    = (pc == m_prev_pc) ? m_same + 1 : 0;
    m_prev_pc = pc;
  endtask

  task automatic compare_model();
    check("tx_valid",    tx_valid,    mq.size() != 0);
    check("tx_data",     tx_data,     (mq.size() != 0) ? mq[0] : 8'h00);
    check("fifo_level",  fifo_level,  mq.size());
    check("overflow",    overflow,    m_ovf);
    check("halt",        halt,        m_halted);
    check("fault",       fault,       m_faulted);
    check("fault_cause", fault_cause, m_cause);
    check("fault_addr",  fault_addr,  m_faddr);
    check("exit_code",   exit_code,   m_exit);
    check("cycle_cnt",   cycle_cnt,   CNT_EN ? m_cyc : 32'd0);
    check("instret_cnt", instret_cnt, CNT_EN ? m_ins : 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  bit          pc_fixed = 0;
  logic [31:0] cur_pc   = 32'h100;

  // One clock: inputs are already applied; sample outputs 1 ns after the edge.
  task automatic tick();
    if (!pc_fixed) begin
      pc     = cur_pc;
      cur_pc = (cur_pc + 32'd4) & 32'h0001_fffc;
    end
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_strb = 0; resetb = 0;
  endtask

  task automatic do_reset();
    idle();
    resetb = 1;
    tick();
    resetb = 0;
  endtask

  task automatic putc(input logic [7:0] ch);
    wr_en = 1; wr_addr = DEFAULT_PUTC_ADDR; wr_data = {24'h0, ch}; wr_strb = 4'b0001;
  endtask

  typedef struct {
    logic        wr_en;
    logic [31:0] addr;
    logic [7:0]  data;
    logic [3:0]  strb;
    logic        ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [4:0]  exp_level;
  } vec_t;

  vec_t        vecs[7];
  logic [7:0]  got[$];
  int          hold_left;
  int          ready_pct;

  initial begin
    vecs[0] = '{1'b1, DEFAULT_PUTC_ADDR, 8'h48, 4'b0001, 1'b1, 1'b1, 8'h48, 5'd1};
    vecs[1] = '{1'b1, DEFAULT_PUTC_ADDR, 8'h69, 4'b0001, 1'b1, 1'b1, 8'h69, 5'd1};
    vecs[2] = '{1'b0, 32'h0,             8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[3] = '{1'b1, DEFAULT_PUTC_ADDR, 8'h78, 4'b1110, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[4] = '{1'b1, 32'h0000_0100,     8'h77, 4'b1111, 1'b1, 1'b0, 8'h00, 5'd0};
    vecs[5] = '{1'b1, DEFAULT_PUTC_ADDR, 8'h7a, 4'b1111, 1'b0, 1'b1, 8'h7a, 5'd1};
    vecs[6] = '{1'b0, 32'h0,             8'h00, 4'b0000, 1'b1, 1'b0, 8'h00, 5'd0};

    idle();
    pc = 0; retire = 0; tx_ready = 0;
    model_reset();

    // Reset state.
    do_reset();
    do_reset();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_halt", halt, 1'b0);
    check("rst_level", fifo_level, 5'd0);
    check("rst_cause", fault_cause, CAUSE_NONE);

    // Console vectors: 'H', 'i', masked strobe, plain DMEM write, stalled sink.
    foreach (vecs[i]) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].addr; wr_data = {24'hABCDEF, vecs[i].data};
      wr_strb = vecs[i].strb; tx_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d_valid", i), tx_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_data", i), tx_data, vecs[i].exp_data);
      check($sformatf("vec%0d_level", i), fifo_level, vecs[i].exp_level);
    end
    idle();

    // Overflow: 17 writes into a stalled 16-entry FIFO, then drain.
    do_reset();
    tx_ready = 0;
    for (int i = 0; i < 17; i++) begin
      putc(8'h10 + 8'(i));
      tick();
    end
    idle();
    check("ovf_level", fifo_level, 5'd16);
    check("ovf_flag", overflow, 1'b1);
    tx_ready = 1;
    got.delete();
    for (int k = 0; k < 40 && tx_valid; k++) begin
      got.push_back(tx_data);
      tick();
    end
    check("ovf_drain_count", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check($sformatf("ovf_byte%0d", i), got[i], 8'h10 + 8'(i));
    check("ovf_sticky", overflow, 1'b1);

    // EXIT with buffered bytes: drain, then halt the cycle after the last pop.
    do_reset();
    tx_ready = 0; retire = 1;
    putc(8'h41); tick();
    putc(8'h42); tick();
    putc(8'h43); tick();
    wr_en = 1; wr_addr = DEFAULT_EXIT_ADDR; wr_data = 32'h2a; wr_strb = 4'b1111;
    tick();
    idle();
    check("exit_halt_early", halt, 1'b0);
    check("exit_code_cap", exit_code, 32'h2a);
    check("exit_level", fifo_level, 5'd3);
    tx_ready = 1;
    tick(); check("drain1_halt", halt, 1'b0);
    tick(); check("drain2_halt", halt, 1'b0);
    tick(); check("drain3_halt", halt, 1'b1);
    check("drain3_level", fifo_level, 5'd0);
    putc(8'h55); tick(); idle();
    tick(); tick();
    check("done_putc_ignored", tx_valid, 1'b0);
    check("done_cycle_frozen", cycle_cnt, CNT_EN ? 32'd7 : 32'd0);
    check("done_instret_frozen", instret_cnt, CNT_EN ? 32'd7 : 32'd0);
    check("done_no_fault", fault, 1'b0);
    retire = 0;

    // Timeout: pc held at 0x40 faults on the 6th edge.
    do_reset();
    pc_fixed = 1; pc = 32'h40;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check($sformatf("tmo_edge%0d_fault", e), fault, e == 6);
    end
    check("tmo_cause", fault_cause, CAUSE_TIMEOUT);
    check("tmo_addr", fault_addr, 32'h40);
    check("tmo_halt", halt, 1'b1);

    // A pc change one cycle earlier avoids it.
    do_reset();
    for (int e = 1; e <= 5; e++) tick();
    pc = 32'h44;
    tick();
    check("tmo_avoid_fault", fault, 1'b0);
    tick();
    check("tmo_avoid_fault2", fault, 1'b0);

    // IMEM wins over DMEM in the same cycle.
    do_reset();
    pc = 32'h0004_0000; wr_en = 1; wr_addr = 32'h0010_0000; wr_strb = 4'hf;
    tick(); idle();
    check("imem_cause", fault_cause, CAUSE_IMEM);
    check("imem_addr", fault_addr, 32'h0004_0000);
    check("imem_halt", halt, 1'b1);

    // DMEM alone; legal boundaries do not fault; first illegal fetch does.
    pc = 32'h100; do_reset();
    wr_en = 1; wr_addr = 32'h0010_0000; wr_strb = 4'hf;
    tick(); idle();
    check("dmem_cause", fault_cause, CAUSE_DMEM);
    check("dmem_addr", fault_addr, 32'h0010_0000);
    do_reset();
    pc = 32'h0001_fffc; wr_en = 1; wr_addr = 32'h0003_fffc; wr_strb = 4'hf;
    tick(); idle();
    check("edge_legal_fault", fault, 1'b0);
    pc = 32'h0002_0000;
    tick();
    check("edge_imem_cause", fault_cause, CAUSE_IMEM);
    pc_fixed = 0;

    // Reset mid-DRAIN discards everything; console works afterwards.
    do_reset();
    tx_ready = 0;
    putc(8'h31); tick();
    putc(8'h32); tick();
    wr_en = 1; wr_addr = DEFAULT_EXIT_ADDR; wr_data = 32'h7; wr_strb = 4'hf;
    tick();
    do_reset();
    check("mid_rst_valid", tx_valid, 1'b0);
    check("mid_rst_level", fifo_level, 5'd0);
    check("mid_rst_exit", exit_code, 32'h0);
    check("mid_rst_halt", halt, 1'b0);
    putc(8'h55); tick(); idle();
    check("post_rst_valid", tx_valid, 1'b1);
    check("post_rst_data", tx_data, 8'h55);

    // Randomized traffic against the model.
    do_reset();
    hold_left = 0;
    ready_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      int r;
      idle();
      if ((c % 64) == 0) ready_pct = $urandom_range(0, 100);
      tx_ready = ($urandom_range(0, 99) < ready_pct);
      retire   = $urandom_range(0, 1);
      wr_data  = $urandom;
      wr_strb  = 4'($urandom);
      r = $urandom_range(0, 99);
      if (r < 30)      begin wr_en = 1; wr_addr = DEFAULT_PUTC_ADDR; end
      else if (r < 32) begin wr_en = 1; wr_addr = DEFAULT_EXIT_ADDR; end
      else if (r < 50) begin wr_en = 1; wr_addr = $urandom & 32'h0003_fffc; end
      else if (r < 51) begin wr_en = 1; wr_addr = $urandom | 32'h0004_0000; end
      if (hold_left > 0) begin
        hold_left--;
        pc_fixed = 1;
      end else begin
        pc_fixed = 0;
        if ($urandom_range(0, 99) < 4) hold_left = $urandom_range(2, 8);
      end
      if (!pc_fixed && $urandom_range(0, 199) == 0) begin
        pc_fixed = 1;
        pc = $urandom | 32'h0002_0000;
      end
      if ((m_halted && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0)
        resetb = 1;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mmio_monitor

// File: doc/mmio_monitor.md
Name: mmio_monitor

Overview:
- Synthesizable successor to the bench-side console, exit and watchdog checks around the three-stage core.
- Snoops the core's data-memory write port and fetch PC.
- Buffers PUTC characters in a parametrised FIFO with a valid/ready drain port, and captures the EXIT code.
- Detects IMEM/DMEM range violations and PC-stall timeout.
- Optionally counts cycles and retired instructions.
- Sits beside execute/IF_ID; its outputs drive the bench or an on-chip UART.

Parameters:
- ADDR_W, 32, address width of wr_addr and pc
- PUTC_ADDR, 32'h8000001c, console byte address
- EXIT_ADDR, 32'h8000002c, exit register address
- IMEM_LOG2, 17, legal fetch space is pc < 2**IMEM_LOG2
- DMEM_LOG2, 18, legal write space is wr_addr < 2**DMEM_LOG2
- FIFO_DEPTH, 16, console FIFO entries; power of two, >= 2
- TIMEOUT_CYCLES, 100, stall threshold in cycles
- CNT_W, 32, counter width

Ports:
- clk  in  1  clock
- resetb  in  1  reset; synchronous, active-high (1 = reset)
- wr_en  in  1  data-memory write strobe (dmem_wready)
- wr_addr  in  ADDR_W  byte write address
- wr_data  in  32  write data
- wr_strb  in  4  byte strobes
- pc  in  ADDR_W  fetch PC (if_pc)
- retire  in  1  one instruction retired this cycle
- tx_valid  out  1  FIFO head valid
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  sink accepts head
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- overflow  out  1  sticky; a character was dropped
- halt  out  1  sticky; program ended or faulted
- exit_code  out  32  captured EXIT data
- fault  out  1  sticky fault flag
- fault_cause  out  2  0 none, 1 IMEM range, 2 DMEM range, 3 timeout
- fault_addr  out  ADDR_W  offending pc or wr_addr
- cycle_cnt  out  CNT_W  cycles since reset
- instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty; state RUN.
  - prev_pc = 0, stall_cnt = 0.
  - Reset asserted mid-operation (any state, including mid-drain) returns to these values on the next edge; buffered characters are discarded.
- States:
  - RUN: normal operation.
  - DRAIN: wait for FIFO empty; goes to DONE when empty.
  - DONE: halt = 1.
  - FAULT: halt = 1 and fault = 1.
  - DONE and FAULT are terminal until reset.
- FIFO:
  - Show-ahead; tx_data is valid whenever tx_valid = !empty.
  - A pop occurs when tx_valid && tx_ready.
  - Push-to-tx_valid latency is 1 cycle.
- PUTC, in RUN only: wr_en && wr_addr == PUTC_ADDR && wr_strb[0] pushes wr_data[7:0].
  - If full with no simultaneous pop, the byte is dropped and overflow is set.
  - Push and pop in the same cycle while full: both accepted; level unchanged.
- EXIT, in RUN only: wr_en && wr_addr == EXIT_ADDR.
  - exit_code <= wr_data.
  - Next state is DONE if the FIFO is empty after this cycle's pop, otherwise DRAIN.
- PUTC/EXIT writes outside RUN are ignored. Draining continues in every state.
- DMEM fault: wr_en, wr_addr not PUTC/EXIT, and wr_addr[ADDR_W-1:DMEM_LOG2] != 0.
- IMEM fault: pc[ADDR_W-1:IMEM_LOG2] != 0, checked every cycle.
- Timeout:
  - Each cycle prev_pc <= pc.
  - If pc == prev_pc, stall_cnt increments (saturating); otherwise stall_cnt clears.
  - A match while stall_cnt == TIMEOUT_CYCLES raises the timeout fault.
- Fault entry:
  - Fault checks apply in RUN and DRAIN.
  - Priority in one cycle: IMEM > DMEM > EXIT > timeout.
  - fault_cause and fault_addr are captured in the same edge that enters FAULT.
- Counters:
  - cycle_cnt increments every cycle in RUN and DRAIN.
  - instret_cnt increments on retire in RUN and DRAIN.
  - Both freeze in DONE/FAULT and wrap modulo 2**CNT_W.
  - The EXIT-write cycle counts.

Optional Feature:
- MMIO_MONITOR_CNT_EN defined: cycle_cnt and instret_cnt are implemented as above.
- Undefined: the counter registers are removed and both outputs are tied to 0; all other behaviour is unchanged.

Decomposition:
- Package mmio_monitor_pkg holds:
  - state encoding (RUN, DRAIN, DONE, FAULT);
  - fault cause codes (CAUSE_NONE, CAUSE_IMEM, CAUSE_DMEM, CAUSE_TIMEOUT);
  - default PUTC/EXIT addresses, shared with the bench.
- One sub-module, mmio_monitor_fifo: synchronous show-ahead FIFO, parametrised by width and depth, with push, pop, full, empty and level.

Test Plan:
- Write 'H' (0x48) then 'i' (0x69) to PUTC with tx_ready = 1 -> tx_data 0x48 one cycle after the first write, then 0x69; fifo_level returns to 0.
- tx_ready = 0, FIFO_DEPTH = 16, 17 PUTC writes -> fifo_level = 16, overflow = 1; then draining yields exactly the first 16 bytes.
- 3 bytes buffered with tx_ready = 0, then EXIT write of 0x2a -> state DRAIN, halt = 0; assert tx_ready -> halt = 1 the cycle after the last pop; exit_code = 0x2a; counters frozen.
- TIMEOUT_CYCLES = 4, pc held at 0x40 -> fault = 1, fault_cause = 3, fault_addr = 0x40 on the 6th edge after pc first equals 0x40; a pc change one cycle earlier prevents the fault.
- Same cycle: wr_addr = 0x00100000 and pc = 0x00040000 (IMEM_LOG2 = 17) -> fault_cause = 1, fault_addr = 0x00040000; halt = 1.
- Assert resetb mid-DRAIN -> next edge: FIFO empty, all outputs 0; a PUTC write afterwards is accepted normally.
